assoc_layer_controller: RTL and testbench

//  Sequences associative-layer learning after the memory layer has resolved a key/response node pair.
//  On each start pulse it scans the association table in an external single-port RAM for the
//  (key,resp) pair, then does exactly one of:
//    - strengthen a matching entry,
//    - insert the pair into a free slot,
//    - evict the weakest entry.
//  It then pulses done. It sits between the memory layer controller (start/done handshake) and the

---
 rtl/assoc_layer_controller.sv | 188 ++++++++++++++++++
 tb/tb_assoc_layer_controller.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/assoc_layer_controller.sv
// Associative-layer learning sequencer.
// Scans the association table for the (key,resp) pair captured with a start pulse. A matching
// entry is strengthened; otherwise the pair goes into the first free slot or, on a full table,
// replaces the weakest entry.
// Optional feature macro: ASSOC_STATS_EN adds saturating hit_count / replace_count outputs.
module assoc_layer_controller #(
  parameter int unsigned NODE_W      = 6,
  parameter int unsigned ASSOC_DEPTH = 16,
  parameter int unsigned ADDR_W      = $clog2(ASSOC_DEPTH),
  parameter int unsigned WEIGHT_W    = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           assoc_learning_start,
  input  logic [NODE_W-1:0]              key_node,
  input  logic [NODE_W-1:0]              resp_node,
  output logic                           busy,
  output logic                           assoc_learning_done,
  output logic                           hit,
  output logic                           replaced,
  output logic [ADDR_W-1:0]              mem_addr,
  output logic                           mem_rd_en,
  output logic                           mem_wr_en,
  output logic [1+2*NODE_W+WEIGHT_W-1:0] mem_wdata,
  input  logic [1+2*NODE_W+WEIGHT_W-1:0] mem_rdata
`ifdef ASSOC_STATS_EN
  ,
  output logic [15:0]                    hit_count,
  output logic [15:0]                    replace_count
`endif
);

  typedef enum logic [2:0] {
    StIdle, StScanRd, StScanCmp, StDecide, StUpdate, StInsert, StReplace, StDone
  } state_e;

  state_e state_q, state_d;

  logic [ADDR_W-1:0]   cnt_q, free_addr_q, min_addr_q, match_addr_q;
  logic [NODE_W-1:0]   key_q, resp_q;
  logic [WEIGHT_W-1:0] min_w_q, match_w_q, upd_w;
  logic                free_found_q;

  // Table entry fields: {valid, key, resp, weight}
  logic                rd_valid;
  logic [NODE_W-1:0]   rd_key, rd_resp;
  logic [WEIGHT_W-1:0] rd_weight;
  logic                rd_match, scan_last;

  assign {rd_valid, rd_key, rd_resp, rd_weight} = mem_rdata;
  assign rd_match  = rd_valid && (rd_key == key_q) && (rd_resp == resp_q);
  assign scan_last = (cnt_q == ADDR_W'(ASSOC_DEPTH - 1));
  // Strengthening saturates instead of wrapping to zero
  assign upd_w     = (match_w_q == '1) ? match_w_q : match_w_q + WEIGHT_W'(1);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (assoc_learning_start) state_d = StScanRd;
      StScanRd:  state_d = StScanCmp;
      StScanCmp: begin
        if (rd_match)       state_d = StUpdate;
        else if (scan_last) state_d = StDecide;
        else                state_d = StScanRd;
      end
      StDecide:  state_d = free_found_q ? StInsert : StReplace;
      StUpdate,
      StInsert,
      StReplace: state_d = StDone;
      StDone:    state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Outputs: RAM strobes, address and write data decoded from state
  always_comb begin
    busy                = (state_q != StIdle);
    assoc_learning_done = 1'b0;
    mem_rd_en           = 1'b0;
    mem_wr_en           = 1'b0;
    mem_addr            = '0;
    mem_wdata           = '0;
    unique case (state_q)
      StScanRd: begin
        mem_rd_en = 1'b1;
        mem_addr  = cnt_q;
      end
      StUpdate: begin
        mem_wr_en = 1'b1;
        mem_addr  = match_addr_q;
        mem_wdata = {1'b1, key_q, resp_q, upd_w};
      end
      StInsert: begin
        mem_wr_en = 1'b1;
        mem_addr  = free_addr_q;
        mem_wdata = {1'b1, key_q, resp_q, WEIGHT_W'(1)};
      end
      StReplace: begin
        mem_wr_en = 1'b1;
        mem_addr  = min_addr_q;
        mem_wdata = {1'b1, key_q, resp_q, WEIGHT_W'(1)};
      end
      StDone:  assoc_learning_done = 1'b1;
      default: ;
    endcase
  end

  // Datapath: capture request, track free/weakest slots during scan, latch result flags
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q        <= '0;
      key_q        <= '0;
      resp_q       <= '0;
      free_found_q <= 1'b0;
      free_addr_q  <= '0;
      min_w_q      <= '0;
      min_addr_q   <= '0;
      match_addr_q <= '0;
      match_w_q    <= '0;
      hit          <= 1'b0;
      replaced     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (assoc_learning_start) begin
            key_q        <= key_node;
            resp_q       <= resp_node;
            cnt_q        <= '0;
            free_found_q <= 1'b0;
            min_w_q      <= '1;
            min_addr_q   <= '0;
          end
        end
        StScanCmp: begin
          if (rd_match) begin
            match_addr_q <= cnt_q;
            match_w_q    <= rd_weight;
          end else begin
            if (!rd_valid && !free_found_q) begin
              free_addr_q  <= cnt_q;
              free_found_q <= 1'b1;
            end
            // Strict compare keeps the lowest index on ties
            if (rd_valid && (rd_weight < min_w_q)) begin
              min_w_q    <= rd_weight;
              min_addr_q <= cnt_q;
            end
            if (!scan_last) cnt_q <= cnt_q + ADDR_W'(1);
          end
        end
        StUpdate: begin
          hit      <= 1'b1;
          replaced <= 1'b0;
        end
        StInsert: begin
          hit      <= 1'b0;
          replaced <= 1'b0;
        end
        StReplace: begin
          hit      <= 1'b0;
          replaced <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef ASSOC_STATS_EN
  // Saturating operation statistics, cleared only by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_count     <= '0;
      replace_count <= '0;
    end else begin
      if (state_q == StUpdate && hit_count != 16'hFFFF)      hit_count     <= hit_count + 16'd1;
      if (state_q == StReplace && replace_count != 16'hFFFF) replace_count <= replace_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_assoc_layer_controller.sv
// Directed bench for assoc_layer_controller with a behavioural single-port table RAM.
module tb_assoc_layer_controller;
  localparam int NODE_W      = 6;
  localparam int ASSOC_DEPTH = 16;
  localparam int ADDR_W      = 4;
  localparam int WEIGHT_W    = 8;
  localparam int ENTRY_W     = 1 + 2 * NODE_W + WEIGHT_W;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                start = 1'b0;
  logic [NODE_W-1:0]   key_node = '0, resp_node = '0;
  logic                busy, done, hit, replaced, mem_rd_en, mem_wr_en;
  logic [ADDR_W-1:0]   mem_addr;
  logic [ENTRY_W-1:0]  mem_wdata;
  logic [ENTRY_W-1:0]  mem_rdata = '0;
`ifdef ASSOC_STATS_EN
  logic [15:0]         hit_count, replace_count;
`endif

  logic [ENTRY_W-1:0]  mem [ASSOC_DEPTH];
  int                  checks = 0, errors = 0, wr_count = 0, done_count = 0;
  logic [ADDR_W-1:0]   last_wr_addr = '0;
  logic [ENTRY_W-1:0]  last_wr_data = '0;

  assoc_layer_controller #(
    .NODE_W(NODE_W), .ASSOC_DEPTH(ASSOC_DEPTH), .ADDR_W(ADDR_W), .WEIGHT_W(WEIGHT_W)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .assoc_learning_start(start),
    .key_node            (key_node),
    .resp_node           (resp_node),
    .busy                (busy),
    .assoc_learning_done (done),
    .hit                 (hit),
    .replaced            (replaced),
    .mem_addr            (mem_addr),
    .mem_rd_en           (mem_rd_en),
    .mem_wr_en           (mem_wr_en),
    .mem_wdata           (mem_wdata),
    .mem_rdata           (mem_rdata)
`ifdef ASSOC_STATS_EN
    ,
    .hit_count           (hit_count),
    .replace_count       (replace_count)
`endif
  );

  always #5 clk = ~clk;

  // Table RAM: read data one cycle after the strobe
  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= mem[mem_addr];
    if (mem_wr_en) mem[mem_addr] <= mem_wdata;
  end

  // Bus rule monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (!reset) begin
      checks++;
      if (mem_rd_en && mem_wr_en) begin
        errors++;
        $display("FAIL strobe_overlap: rd_en=1 wr_en=1, required never both");
      end
      checks++;
      if (!mem_rd_en && !mem_wr_en && mem_addr != '0) begin
        errors++;
        $display("FAIL idle_addr: got %0d, required 0", mem_addr);
      end
      if (mem_wr_en) begin
        wr_count++;
        last_wr_addr = mem_addr;
        last_wr_data = mem_wdata;
      end
      if (done) done_count++;
    end
  end

  function automatic logic [ENTRY_W-1:0] ent(logic v, logic [NODE_W-1:0] k,
                                             logic [NODE_W-1:0] r, logic [WEIGHT_W-1:0] w);
    return {v, k, r, w};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Table images used by the vectors
  task automatic load_table(input int kind);
    for (int i = 0; i < ASSOC_DEPTH; i++) begin
      case (kind)
        1:       mem[i] = (i == 4) ? ent(1'b1, 6'd3, 6'd5, 8'd7) : '0;
        2:       mem[i] = (i == 9) ? ent(1'b1, 6'd3, 6'd5, 8'd255) : '0;
        3:       mem[i] = ent(1'b1, NODE_W'(i + 10), 6'd1, (i == 6 || i == 11) ? 8'd2 : 8'd9);
        4:       mem[i] = (i == 15) ? ent(1'b1, 6'd3, 6'd5, 8'd100)
                                    : ent(1'b1, NODE_W'(i + 10), 6'd1, WEIGHT_W'(i * 7 + 20));
        5:       mem[i] = (i == 0) ? ent(1'b1, 6'd3, 6'd6, 8'd4) :
                          (i == 1) ? ent(1'b0, 6'd3, 6'd5, 8'd50) :
                          (i == 2) ? ent(1'b1, 6'd5, 6'd3, 8'd4) : '0;
        6:       mem[i] = ent(1'b1, NODE_W'(i + 10), 6'd1, 8'd9);
        7:       mem[i] = ent(1'b1, NODE_W'(i + 10), 6'd1, 8'd255);
        default: mem[i] = '0;
      endcase
    end
  endtask

  // Pulse start for one cycle, then scramble the node inputs; returns cycle of done
  task automatic run_op(input logic [NODE_W-1:0] k, input logic [NODE_W-1:0] r,
                        output int cyc);
    @(negedge clk);
    key_node  = k;
    resp_node = r;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start     = 1'b0;
    key_node  = ~k;
    resp_node = ~r;
    cyc = 1;
    check("busy_after_start", 32'(busy), 32'd1);
    while (!done && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  typedef struct {
    int                  kind;
    logic [NODE_W-1:0]   key;
    logic [NODE_W-1:0]   resp;
    int                  cyc;
    logic [ADDR_W-1:0]   addr;
    logic [WEIGHT_W-1:0] w;
    logic                hit;
    logic                rep;
  } vec_t;

  vec_t vecs[8];
  int   cyc, w0, d0, first_done, exp_hits, exp_reps;

  initial begin
    vecs[0] = '{0, 6'd3, 6'd5, 35, 4'd0,  8'd1,   1'b0, 1'b0}; // empty: insert at 0
    vecs[1] = '{1, 6'd3, 6'd5, 12, 4'd4,  8'd8,   1'b1, 1'b0}; // match at 4
    vecs[2] = '{2, 6'd3, 6'd5, 22, 4'd9,  8'd255, 1'b1, 1'b0}; // saturated weight
    vecs[3] = '{3, 6'd3, 6'd5, 35, 4'd6,  8'd1,   1'b0, 1'b1}; // weakest, tie -> 6
    vecs[4] = '{4, 6'd3, 6'd5, 34, 4'd15, 8'd101, 1'b1, 1'b0}; // match at last index
    vecs[5] = '{5, 6'd3, 6'd5, 35, 4'd1,  8'd1,   1'b0, 1'b0}; // invalid lookalike is free
    vecs[6] = '{6, 6'd3, 6'd5, 35, 4'd0,  8'd1,   1'b0, 1'b1}; // all equal -> 0
    vecs[7] = '{7, 6'd3, 6'd5, 35, 4'd0,  8'd1,   1'b0, 1'b1}; // all max weight -> 0
    exp_hits = 0;
    exp_reps = 0;
    load_table(0);

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_hit", 32'(hit), 32'd0);
    check("rst_replaced", 32'(replaced), 32'd0);
    check("rst_strobes", 32'({mem_rd_en, mem_wr_en}), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(posedge clk);

    foreach (vecs[n]) begin
      load_table(vecs[n].kind);
      w0 = wr_count;
      d0 = done_count;
      run_op(vecs[n].key, vecs[n].resp, cyc);
      check($sformatf("v%0d_done_cycle", n), 32'(cyc), 32'(vecs[n].cyc));
      check($sformatf("v%0d_hit", n), 32'(hit), 32'(vecs[n].hit));
      check($sformatf("v%0d_replaced", n), 32'(replaced), 32'(vecs[n].rep));
      check($sformatf("v%0d_busy_in_done", n), 32'(busy), 32'd1);
      @(posedge clk);
      #1;
      check($sformatf("v%0d_done_pulse", n), 32'(done), 32'd0);
      check($sformatf("v%0d_idle", n), 32'(busy), 32'd0);
      check($sformatf("v%0d_writes", n), 32'(wr_count - w0), 32'd1);
      check($sformatf("v%0d_dones", n), 32'(done_count - d0), 32'd1);
      check($sformatf("v%0d_wr_addr", n), 32'(last_wr_addr), 32'(vecs[n].addr));
      check($sformatf("v%0d_wr_data", n), 32'(last_wr_data),
            32'(ent(1'b1, vecs[n].key, vecs[n].resp, vecs[n].w)));
      check($sformatf("v%0d_ram", n), 32'(mem[vecs[n].addr]),
            32'(ent(1'b1, vecs[n].key, vecs[n].resp, vecs[n].w)));
      if (vecs[n].hit) exp_hits++;
      if (vecs[n].rep) exp_reps++;
    end

`ifdef ASSOC_STATS_EN
    check("hit_count", 32'(hit_count), 32'(exp_hits));
    check("replace_count", 32'(replace_count), 32'(exp_reps));
`endif

    // Second start while busy is dropped: one done, one write, original timing
    load_table(0);
    w0 = wr_count;
    d0 = done_count;
    first_done = 0;
    @(negedge clk);
    key_node = 6'd3;
    resp_node = 6'd5;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int c = 1; c <= 80; c++) begin
      if (c == 5) start = 1'b1;
      if (c == 6) start = 1'b0;
      if (done && first_done == 0) first_done = c;
      @(posedge clk);
      #1;
    end
    check("dbl_done_cycle", 32'(first_done), 32'd35);
    check("dbl_dones", 32'(done_count - d0), 32'd1);
    check("dbl_writes", 32'(wr_count - w0), 32'd1);

    // Reset mid-scan aborts with no write and no done
    load_table(0);
    w0 = wr_count;
    d0 = done_count;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int c = 1; c < 10; c++) begin
      if (c == 5) start = 1'b1;
      if (c == 6) start = 1'b0;
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_hit", 32'(hit), 32'd0);
    check("abort_replaced", 32'(replaced), 32'd1 & 32'd0);
`ifdef ASSOC_STATS_EN
    check("abort_hit_count", 32'(hit_count), 32'd0);
    check("abort_replace_count", 32'(replace_count), 32'd0);
`endif
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("abort_writes", 32'(wr_count - w0), 32'd0);
    check("abort_dones", 32'(done_count - d0), 32'd0);
    check("abort_ram", 32'(mem[0]), 32'd0);
    check("abort_stays_idle", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
